uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 166 ++++++++++++++++
 tb/tb_uart_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - queue-fed UART transmitter, 8N1 framing with optional even parity
//
// Pops one word from a FIFO-style source (in/em/pp) and sends it as a serial
// frame: start bit (0), NBITS data bits LSB first, optional even parity bit,
// stop bit (1). Each bit is held for CLKS_PER_BIT clock cycles.
//
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
//
// Ports:
//   ck    in   system clock, rising-edge active
//   rst   in   asynchronous active-low reset
//   in    in   NBITS head-of-queue data word
//   em    in   queue empty flag (1 = nothing to send)
//   pp    out  pop request, registered one-cycle pulse per frame
//   tx    out  registered serial line, idles high
//   busy  out  high whenever a frame is in progress
module uart_tx #(
   parameter int NBITS        = 8,
   parameter int CLKS_PER_BIT = 434
) (
   input  logic             ck,
   input  logic             rst,
   input  logic [NBITS-1:0] in,
   input  logic             em,
   output logic             pp,
   output logic             tx,
   output logic             busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NBITS - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t            state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [IW-1:0]     idx, idx_n;
   logic [NBITS-1:0]  sh, sh_n;
   logic              tx_n;
   logic              pp_n;
   logic              bit_done;
`ifdef UART_TX_PARITY_EN
   logic              par, par_n;
`endif

   assign busy     = (state != IDLE);
   assign bit_done = (cnt == CNT_LAST);

   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         sh    <= '0;
         tx    <= 1'b1;
         pp    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         sh    <= sh_n;
         tx    <= tx_n;
         pp    <= pp_n;
`ifdef UART_TX_PARITY_EN
         par   <= par_n;
`endif
      end
   end

   // tx_n is the value the line takes during the cycle after this edge, so
   // each transition loads the first bit of the state being entered.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      sh_n    = sh;
      tx_n    = tx;
      pp_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_n   = par;
`endif
      case (state)
         IDLE: begin
            tx_n = 1'b1;
            if (!em) begin
               sh_n    = in;
               cnt_n   = '0;
               idx_n   = '0;
               pp_n    = 1'b1;
               tx_n    = 1'b0;
               state_n = START;
`ifdef UART_TX_PARITY_EN
               // Parity is taken at launch because the shift register is
               // consumed while the data bits go out.
               par_n   = ^in;
`endif
            end
         end
         START: begin
            if (bit_done) begin
               cnt_n   = '0;
               idx_n   = '0;
               tx_n    = sh[0];
               state_n = DATA;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         DATA: begin
            if (bit_done) begin
               cnt_n = '0;
               if (idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                  tx_n    = par;
                  state_n = PARITY;
`else
                  tx_n    = 1'b1;
                  state_n = STOP;
`endif
               end else begin
                  idx_n = idx + IW'(1);
                  sh_n  = sh >> 1;
                  tx_n  = sh[1];
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_done) begin
               cnt_n   = '0;
               tx_n    = 1'b1;
               state_n = STOP;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
`endif
         STOP: begin
            tx_n = 1'b1;
            if (bit_done) begin
               cnt_n   = '0;
               state_n = IDLE;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: begin
            cnt_n   = '0;
            tx_n    = 1'b1;
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx (NBITS=8, CLKS_PER_BIT=4)
//
// Expected line activity is built from the frame rules: a frame is a list of
// bits (start, data LSB first, optional parity, stop), each lasting CPB
// cycles, followed by one idle cycle before the next queued word launches.
module tb_uart_tx;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FW = 11;
`else
   localparam int FW = 10;
`endif
   localparam int FL = FW * CPB;

   logic       ck;
   logic       rst;
   logic [7:0] din;
   logic       em;
   logic       pp;
   logic       tx;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [7:0]    data;
      logic [FW-1:0] frame;   // bit i = i-th bit on the line
   } vec_t;

   vec_t          tbl[5];
   logic [7:0]    stream[8];
   logic [FW-1:0] exp_frame[8];

   uart_tx #(.NBITS(8), .CLKS_PER_BIT(CPB)) dut (
      .ck(ck), .rst(rst), .in(din), .em(em), .pp(pp), .tx(tx), .busy(busy)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;
   always @(posedge ck) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [FW-1:0] mk_frame(input logic [7:0] b);
      logic [FW-1:0] f;
      f = '0;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
      f[9] = ^b;
`endif
      f[FW-1] = 1'b1;
      return f;
   endfunction

   // Called at a negedge; sends n queued words back to back while throwing
   // garbage at in/em whenever the transmitter should be ignoring them.
   task automatic run_stream(input int n);
      int last_pp;
      last_pp = 0;
      din = stream[0];
      em  = 1'b0;
      for (int f = 0; f < n; f++) begin
         for (int k = 0; k <= FL; k++) begin
            @(negedge ck);
            chk("tx",   32'(tx),   (k == FL) ? 32'd1 : 32'(exp_frame[f][k / CPB]));
            chk("pp",   32'(pp),   32'(k == 0));
            chk("busy", 32'(busy), 32'(k != FL));
            if (k == 0) begin
               if (f > 0) chk("pp_spacing", 32'(cyc - last_pp), 32'(FL + 1));
               last_pp = cyc;
            end
            if (k == FL) begin
               if (f + 1 < n) begin
                  din = stream[f+1];
                  em  = 1'b0;
               end else begin
                  din = 8'($urandom);
                  em  = 1'b1;
               end
            end else begin
               din = 8'($urandom);
               em  = 1'($urandom_range(0, 1));
            end
         end
      end
   endtask

   initial begin
      tbl[0] = '{8'hA5, 0};
      tbl[1] = '{8'h00, 0};
      tbl[2] = '{8'hFF, 0};
      tbl[3] = '{8'h3C, 0};
      tbl[4] = '{8'h07, 0};
`ifdef UART_TX_PARITY_EN
      tbl[0].frame = 11'b10101001010;
      tbl[1].frame = 11'b10000000000;
      tbl[2].frame = 11'b10111111110;
      tbl[3].frame = 11'b10001111000;
      tbl[4].frame = 11'b11000001110;
`else
      tbl[0].frame = 10'b1101001010;
      tbl[1].frame = 10'b1000000000;
      tbl[2].frame = 10'b1111111110;
      tbl[3].frame = 10'b1001111000;
      tbl[4].frame = 10'b1000001110;
`endif

      rst = 1'b0;
      em  = 1'b0;
      din = 8'h5A;

      // Reset held with data available: nothing may move.
      for (int i = 0; i < 5; i++) begin
         @(negedge ck);
         chk("rst_tx", 32'(tx), 32'd1);
         chk("rst_pp", 32'(pp), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
      end
      em  = 1'b1;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge ck);
         chk("post_rst_pp", 32'(pp), 32'd0);
         chk("post_rst_busy", 32'(busy), 32'd0);
      end

      // Empty queue for 100 cycles.
      for (int i = 0; i < 100; i++) begin
         din = 8'($urandom);
         @(negedge ck);
         chk("idle_pp", 32'(pp), 32'd0);
         chk("idle_tx", 32'(tx), 32'd1);
         chk("idle_busy", 32'(busy), 32'd0);
      end

      // Single-frame vectors with hand-written expected line bits.
      for (int i = 0; i < 5; i++) begin
         stream[0]    = tbl[i].data;
         exp_frame[0] = tbl[i].frame;
         run_stream(1);
         @(negedge ck);
         chk("after_frame_pp", 32'(pp), 32'd0);
      end

      // Back-to-back 0x00 then 0xFF, then 0x07 twice.
      stream[0] = 8'h00; exp_frame[0] = tbl[1].frame;
      stream[1] = 8'hFF; exp_frame[1] = tbl[2].frame;
      stream[2] = 8'h07; exp_frame[2] = tbl[4].frame;
      stream[3] = 8'h07; exp_frame[3] = tbl[4].frame;
      run_stream(4);

      // Reset during data bit 3 of 0x3C.
      @(negedge ck);
      din = 8'h3C;
      em  = 1'b0;
      for (int k = 0; k < 18; k++) begin
         @(negedge ck);
         if (k == 0) em = 1'b1;
         chk("pre_abort_tx", 32'(tx), 32'(tbl[3].frame[k / CPB]));
      end
      rst = 1'b0;
      em  = 1'b0;
      #1;
      chk("abort_tx", 32'(tx), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_pp", 32'(pp), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge ck);
         chk("abort_hold_pp", 32'(pp), 32'd0);
         chk("abort_hold_tx", 32'(tx), 32'd1);
      end
      rst = 1'b1;
      stream[0]    = 8'h3C;
      exp_frame[0] = tbl[3].frame;
      run_stream(1);

      // Randomized streams against the frame model.
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 8; i++) begin
            stream[i]    = 8'($urandom);
            exp_frame[i] = mk_frame(stream[i]);
         end
         @(negedge ck);
         run_stream(8);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
